// File: rtl/spi2adc.sv
// spi2adc: MCP3002 SPI master (mode 0,0, MSB first), one 10-bit conversion per accepted start.
// Latency 34*DIV+1 cycles start->data_valid; start is ignored (not queued) while busy.
module spi2adc #(
  parameter int unsigned DIV = 25
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       start,
  input  logic       channel,
  input  logic       adc_sdo,
  output logic       adc_cs,
  output logic       adc_sdi,
  output logic       adc_sck,
  output logic [9:0] data_out,
  output logic       data_valid,
  output logic       busy
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] div_cnt;
  logic [4:0]    half_cnt;
  logic [4:0]    half_nxt;
  logic          phase_end;
  logic          ch_lat;
  logic [9:0]    sreg;
  logic          sample;
  logic          cs_nxt;
  logic          sck_nxt;
  logic          sdi_nxt;
  logic          busy_nxt;

  assign phase_end = (div_cnt == DIV_LAST);

  // half_cnt counts SCK half-periods in SHIFT: even = low phase, odd = high phase.
  assign sample = (state == SHIFT) && phase_end && !half_cnt[0] &&
                  (half_cnt[4:1] >= 4'd5) && (half_cnt[4:1] <= 4'd14);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = CS_SETUP;
      CS_SETUP: if (phase_end) state_nxt = SHIFT;
      SHIFT:    if (phase_end && (half_cnt == 5'd31)) state_nxt = CS_HOLD;
      CS_HOLD:  if (phase_end) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    half_nxt = half_cnt;
    if (state != SHIFT) begin
      half_nxt = 5'd0;
    end else if (phase_end) begin
      half_nxt = half_cnt + 5'd1;
    end

    cs_nxt   = !(state_nxt inside {CS_SETUP, SHIFT, CS_HOLD});
    sck_nxt  = (state_nxt == SHIFT) && half_nxt[0];
    busy_nxt = (state_nxt != IDLE);

    // Command bit for the SCK period being entered; only changes while SCK is low.
    sdi_nxt = 1'b0;
    if (state_nxt == CS_SETUP) begin
      sdi_nxt = 1'b1;
    end else if (state_nxt == SHIFT) begin
      case (half_nxt[4:1])
        4'd0, 4'd1, 4'd3: sdi_nxt = 1'b1;
        4'd2:             sdi_nxt = ch_lat;
        default:          sdi_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      div_cnt    <= '0;
      half_cnt   <= '0;
      ch_lat     <= 1'b0;
      sreg       <= '0;
      adc_cs     <= 1'b1;
      adc_sck    <= 1'b0;
      adc_sdi    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if ((state inside {CS_SETUP, SHIFT, CS_HOLD}) && !phase_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
      end
      half_cnt <= half_nxt;

      if ((state == IDLE) && start) begin
        ch_lat <= channel;
      end
      if (sample) begin
        sreg <= {sreg[8:0], adc_sdo};
      end

      adc_cs     <= cs_nxt;
      adc_sck    <= sck_nxt;
      adc_sdi    <= sdi_nxt;
      busy       <= busy_nxt;
      data_valid <= (state == DONE);
      if (state == DONE) begin
        data_out <= sreg;
      end
    end
  end

endmodule

// File: tb/tb_spi2adc.sv
// Bench for spi2adc: behavioural MCP3002 model plus transaction-level expectations.
// Main instance runs at DIV=2; a second instance at DIV=25 is paced by a 5000-cycle tick.
`timescale 1ns/1ps
module tb_spi2adc;

  localparam int DIV   = 2;
  localparam int DIV25 = 25;
  localparam int LAT   = 34 * DIV + 1;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       start;
  logic       channel;
  logic       adc_sdo = 1'b0;
  logic       adc_cs;
  logic       adc_sdi;
  logic       adc_sck;
  logic [9:0] data_out;
  logic       data_valid;
  logic       busy;

  logic       start25;
  logic       channel25;
  logic       sdo25;
  logic       cs25;
  logic       sdi25;
  logic       sck25;
  logic [9:0] dout25;
  logic       valid25;
  logic       busy25;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  spi2adc #(.DIV(DIV)) u_dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .start     (start),
    .channel   (channel),
    .adc_sdo   (adc_sdo),
    .adc_cs    (adc_cs),
    .adc_sdi   (adc_sdi),
    .adc_sck   (adc_sck),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy)
  );

  spi2adc #(.DIV(DIV25)) u_dut25 (
    .sysclk    (sysclk),
    .reset     (reset),
    .start     (start25),
    .channel   (channel25),
    .adc_sdo   (sdo25),
    .adc_cs    (cs25),
    .adc_sdi   (sdi25),
    .adc_sck   (sck25),
    .data_out  (dout25),
    .data_valid(valid25),
    .busy      (busy25)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // MCP3002 model: captures the 4 command bits on rising SCK, shifts its sample
  // out on falling SCK (null bit in period 5, B9..B0 in periods 6..15).
  logic [9:0] adc_val [2];
  int         rise_cnt   = 0;
  int         last_rises = 0;
  logic [3:0] cmd_seen   = 4'd0;

  always @(posedge adc_sck) begin
    if (rise_cnt < 4) cmd_seen[3 - rise_cnt] = adc_sdi;
    rise_cnt = rise_cnt + 1;
  end

  always @(posedge adc_cs) begin
    last_rises = rise_cnt;
    rise_cnt   = 0;
  end

  always @(negedge adc_sck) begin : adc_drive
    int p;
    p = rise_cnt + 1;
    if (p >= 6 && p <= 15) adc_sdo = adc_val[cmd_seen[1]][15 - p];
    else                   adc_sdo = 1'b0;
  end

  task automatic run_frame(input logic ch, input logic [9:0] v0, input logic [9:0] v1,
                           input bit toggle, input string tag);
    int         t0;
    int         hi;
    int         rises;
    bit         bad;
    logic       prev_sck;
    logic [9:0] exp_val;
    adc_val[0] = v0;
    adc_val[1] = v1;
    exp_val    = ch ? v1 : v0;
    @(negedge sysclk);
    channel = ch;
    start   = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    t0    = cyc;
    chk({tag, "/busy_on"}, busy, 1'b1);
    chk({tag, "/cs_low"}, adc_cs, 1'b0);
    hi = 0; rises = 0; bad = 0; prev_sck = 1'b0;
    while (!data_valid && (cyc - t0) < LAT + 20) begin
      if (toggle && (cyc - t0) == 3) channel = ~ch;
      if (adc_sck) hi++;
      if (adc_sck && !prev_sck) rises++;
      if (adc_sck && adc_cs) bad = 1;
      prev_sck = adc_sck;
      @(negedge sysclk);
    end
    chk({tag, "/latency"}, cyc - t0, LAT);
    chk({tag, "/data"}, data_out, exp_val);
    chk({tag, "/busy_off"}, busy, 1'b0);
    chk({tag, "/cs_high"}, adc_cs, 1'b1);
    chk({tag, "/sck_rises"}, rises, 16);
    chk({tag, "/sck_hi_cycles"}, hi, 16 * DIV);
    chk({tag, "/sck_while_cs_high"}, bad, 1'b0);
    chk({tag, "/model_rises"}, last_rises, 16);
    chk({tag, "/cmd"}, cmd_seen, {1'b1, 1'b1, ch, 1'b1});
    @(negedge sysclk);
    chk({tag, "/valid_width"}, data_valid, 1'b0);
    channel = ch;
  endtask

  initial begin
    int q[$];
    int vcnt;
    int cs_run;
    int min_cs;
    int gaps;
    bit seen_low;
    logic prev_busy;
    int t0;
    int v25;
    int cslow;
    int sckhi;
    int sck_runs;
    int sck_bad;

    reset = 1'b1; start = 1'b0; channel = 1'b0;
    start25 = 1'b0; channel25 = 1'b0; sdo25 = 1'b0;
    adc_val[0] = 10'h0; adc_val[1] = 10'h0;
    repeat (3) @(negedge sysclk);
    chk("rst/cs", adc_cs, 1'b1);
    chk("rst/sck", adc_sck, 1'b0);
    chk("rst/sdi", adc_sdi, 1'b0);
    chk("rst/data", data_out, 10'h0);
    chk("rst/valid", data_valid, 1'b0);
    chk("rst/busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge sysclk);

    run_frame(1'b0, 10'h2A5, 10'h155, 1'b0, "ch0");
    run_frame(1'b1, 10'h0AA, 10'h3FF, 1'b0, "ch1");
    run_frame(1'b1, 10'h3FF, 10'h000, 1'b0, "ch1_zero");
    run_frame(1'b0, 10'h1C3, 10'h23C, 1'b1, "toggle0");
    run_frame(1'b1, 10'h1C3, 10'h23C, 1'b1, "toggle1");

    // start held high: frames must start every 34*DIV+2 cycles, never during busy
    adc_val[0] = 10'h1A7; adc_val[1] = 10'h058;
    q.delete();
    vcnt = 0; cs_run = 0; min_cs = 1000; gaps = 0; seen_low = 0; prev_busy = busy;
    channel = 1'b0;
    start   = 1'b1;
    for (int i = 0; i < 3 * (LAT + 1) + 5; i++) begin
      @(negedge sysclk);
      if (busy && !prev_busy) q.push_back(cyc);
      prev_busy = busy;
      if (data_valid) begin
        vcnt++;
        chk("b2b/data", data_out, adc_val[0]);
      end
      if (!adc_cs) begin
        if (seen_low && cs_run > 0) begin
          gaps++;
          if (cs_run < min_cs) min_cs = cs_run;
        end
        seen_low = 1;
        cs_run   = 0;
      end else if (seen_low) begin
        cs_run++;
      end
    end
    start = 1'b0;
    chk("b2b/frames", q.size(), 4);
    for (int k = 1; k < q.size(); k++) chk("b2b/spacing", q[k] - q[k-1], 34 * DIV + 2);
    chk("b2b/valids", vcnt, 3);
    chk("b2b/cs_gaps", gaps, 3);
    chk("b2b/cs_gap_min_ok", (min_cs >= 1), 1'b1);
    repeat (LAT + 5) @(negedge sysclk);

    // reset during SHIFT period 8 aborts the frame with no published result
    adc_val[0] = 10'h3C1; adc_val[1] = 10'h21E;
    chk("abort/pre_data_nonzero", (data_out != 10'h0), 1'b1);
    channel = 1'b0;
    start   = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    t0    = cyc;
    while ((cyc - t0) < DIV + 14 * DIV + 1) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    chk("abort/cs", adc_cs, 1'b1);
    chk("abort/sck", adc_sck, 1'b0);
    chk("abort/data", data_out, 10'h0);
    chk("abort/busy", busy, 1'b0);
    chk("abort/valid", data_valid, 1'b0);
    reset = 1'b0;
    vcnt  = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge sysclk);
      if (data_valid) vcnt++;
    end
    chk("abort/no_valid", vcnt, 0);
    run_frame(1'b1, 10'h3C1, 10'h21E, 1'b0, "after_abort");

    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge sysclk);
      run_frame(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                10'($urandom_range(0, 1023)), bit'($urandom_range(0, 1)), "rand");
    end

    // DIV=25 instance paced by a clk_tick-style pulse every 5000 cycles
    v25 = 0; cslow = 0; sckhi = 0; sck_runs = 0; sck_bad = 0;
    for (int i = 0; i < 15900; i++) begin
      start25 = (i % 5000 == 4999);
      @(negedge sysclk);
      if (valid25) v25++;
      if (!cs25) begin
        cslow++;
      end else if (cslow > 0) begin
        chk("div25/cs_low_cycles", cslow, 34 * DIV25);
        cslow = 0;
      end
      if (sck25) begin
        sckhi++;
      end else if (sckhi > 0) begin
        sck_runs++;
        if (sckhi != DIV25) sck_bad++;
        sckhi = 0;
      end
    end
    start25 = 1'b0;
    chk("div25/valids", v25, 3);
    chk("div25/sck_periods", sck_runs, 48);
    chk("div25/sck_half_period", sck_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
